// File: rtl/dm_multicore_ctrl_pkg.sv
// dm_pkg: shared types and constant helpers for the dm_multicore_ctrl slice.
//   state_t      : controller FSM states (IDLE serves cores, LOAD runs the loader sequence)
//   dm_log2      : ceil(log2(n)), never less than 1, for index widths
//   dm_addr_mask : low-bit address mask for a power-of-two memory depth
package dm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  function automatic int unsigned dm_log2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned dm_addr_mask(input int unsigned depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/dm_multicore_ctrl_if.sv
// dm_multicore_ctrl_if: core and loader ports of the shared data-memory controller.
//   core_req/core_we/core_addr/core_wdata : per-core request, held until core_ack
//   core_ack/core_rdata                   : one-cycle completion pulse, load data held until next ack
//   ld_valid/ld_ready/ld_addr/ld_data     : bulk loader handshake, NUM_CORES words per transfer
//   ld_done                               : one-cycle pulse after the last loader write
// Modports: master = cores + loader (request side), slave = controller.
interface dm_multicore_ctrl_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16
);
  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_ack;
  logic [NUM_CORES*DATA_W-1:0] core_rdata;
  logic                        ld_valid;
  logic                        ld_ready;
  logic [ADDR_W-1:0]           ld_addr;
  logic [NUM_CORES*DATA_W-1:0] ld_data;
  logic                        ld_done;

  modport master (
    output core_req, core_we, core_addr, core_wdata, ld_valid, ld_addr, ld_data,
    input  core_ack, core_rdata, ld_ready, ld_done
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, ld_valid, ld_addr, ld_data,
    output core_ack, core_rdata, ld_ready, ld_done
  );
endinterface

// File: rtl/dm_multicore_ctrl_rr_arbiter.sv
// dm_rr_arbiter: combinational round-robin pick.
//   eligible : request vector after masking
//   rr_last  : index of the previous winner; search starts at rr_last+1
//   grant    : one-hot winner, idx : winner index, any : a winner exists
// The pointer register lives in the parent.
module dm_rr_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned IW        = 2
) (
  input  logic [NUM_CORES-1:0] eligible,
  input  logic [IW-1:0]        rr_last,
  output logic [NUM_CORES-1:0] grant,
  output logic [IW-1:0]        idx,
  output logic                 any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      cand = IW'((32'(rr_last) + k) % NUM_CORES);
      if (!any && eligible[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_multicore_ctrl.sv
// dm_multicore_ctrl: shared single-port data memory for NUM_CORES cores plus a bulk loader.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dm_multicore_ctrl_if.slave (core request/ack ports, loader handshake)
// IDLE grants one core per cycle round-robin (ack one cycle after the grant) and can accept
// a loader transfer; LOAD writes the NUM_CORES loader words to consecutive addresses
// (wrapping at DEPTH), one per cycle, with core grants held off.
// Optional build macro DM_COALESCE_EN: eligible cores loading the same address as a loading
// winner are served in the same cycle.
module dm_multicore_ctrl import dm_pkg::*; #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  dm_multicore_ctrl_if.slave   bus
);

  localparam int unsigned     AW    = dm_log2(DEPTH);
  localparam int unsigned     KW    = dm_log2(NUM_CORES);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(dm_addr_mask(DEPTH));

  typedef logic [AW-1:0] maddr_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t                      state;
  logic [KW-1:0]               rr_last;
  logic [KW-1:0]               ld_k;
  maddr_t                      ld_base;
  logic [NUM_CORES*DATA_W-1:0] ld_buf;

  maddr_t                      core_ma [NUM_CORES];
  logic [NUM_CORES-1:0]        eligible;
  logic [NUM_CORES-1:0]        grant;
  logic [NUM_CORES-1:0]        serve;
  logic [KW-1:0]               win_idx;
  logic                        win_any;
  maddr_t                      win_ma;
  logic                        win_we;
  logic [DATA_W-1:0]           win_wdata;
  logic                        mem_we;
  maddr_t                      mem_wa;
  logic [DATA_W-1:0]           mem_wd;
  logic [DATA_W-1:0]           rd_word;

  // A core acked this cycle still shows its old request; masking it avoids a double grant.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      core_ma[i] = maddr_t'(bus.core_addr[i*ADDR_W +: ADDR_W] & AMASK);
    end
    eligible = (state == IDLE) ? (bus.core_req & ~bus.core_ack) : '0;
  end

  dm_rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IW        (KW)
  ) u_arb (
    .eligible (eligible),
    .rr_last  (rr_last),
    .grant    (grant),
    .idx      (win_idx),
    .any      (win_any)
  );

  always_comb begin
    win_ma    = core_ma[win_idx];
    win_we    = bus.core_we[win_idx];
    win_wdata = bus.core_wdata[win_idx*DATA_W +: DATA_W];
    rd_word   = mem[win_ma];
  end

  always_comb begin
    serve = grant;
`ifdef DM_COALESCE_EN
    if (win_any && !win_we) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (eligible[i] && !bus.core_we[i] && (core_ma[i] == win_ma)) serve[i] = 1'b1;
      end
    end
`endif
  end

  // Single write port: loader sequence in LOAD, winning store in IDLE.
  // Writes are suppressed in a reset cycle so an aborted load keeps only completed words.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = win_ma;
    mem_wd = win_wdata;
    if (!rst) begin
      if (state == LOAD) begin
        mem_we = 1'b1;
        mem_wa = ld_base + maddr_t'(ld_k);
        mem_wd = ld_buf[ld_k*DATA_W +: DATA_W];
      end else if (win_any && win_we) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_last        <= KW'(NUM_CORES - 1);
      ld_k           <= '0;
      ld_base        <= '0;
      ld_buf         <= '0;
      bus.core_ack   <= '0;
      bus.core_rdata <= '0;
      bus.ld_ready   <= 1'b1;
      bus.ld_done    <= 1'b0;
    end else begin
      bus.core_ack <= serve;
      bus.ld_done  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (serve[i] && !bus.core_we[i]) bus.core_rdata[i*DATA_W +: DATA_W] <= rd_word;
      end
      if (win_any) rr_last <= win_idx;

      case (state)
        IDLE: begin
          if (bus.ld_valid && bus.ld_ready) begin
            ld_base      <= maddr_t'(bus.ld_addr & AMASK);
            ld_buf       <= bus.ld_data;
            ld_k         <= '0;
            bus.ld_ready <= 1'b0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (ld_k == KW'(NUM_CORES - 1)) begin
            ld_k         <= '0;
            bus.ld_done  <= 1'b1;
            bus.ld_ready <= 1'b1;
            state        <= IDLE;
          end else begin
            ld_k <= ld_k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_multicore_ctrl.sv
module tb_dm_multicore_ctrl;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int AWD = 16;

  typedef struct packed {
    logic [1:0]  kind;   // 0 load, 1 store, 2 idle cycle
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct packed {
    logic        we;
    logic [15:0] data;
    int          ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  cmd_t cmdq [NC][$];
  exp_t expq [NC][$];
  int   order_q [$];
  bit   lat_chk = 0;
  bit   order_chk = 0;
  int   last_ack_cyc [NC];
  int   ld_done_cyc;

  logic [15:0] model [256];
  bit          gvalid [256];

  dm_multicore_ctrl_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AWD)) bus ();

  dm_multicore_ctrl #(
    .NUM_CORES (NC),
    .DATA_W    (DW),
    .ADDR_W    (AWD),
    .DEPTH     (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic [1:0] kind, input logic [15:0] a, input logic [15:0] d);
    cmd_t c;
    c.kind = kind;
    c.addr = a;
    c.data = d;
    return c;
  endfunction

  // One driver thread for all cores: keeps each request up until its ack, then issues the next.
  task automatic driver_loop();
    bit   busy [NC];
    cmd_t k;
    exp_t e;
    for (int c = 0; c < NC; c++) busy[c] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int c = 0; c < NC; c++) begin
        if (busy[c] && bus.core_ack[c]) busy[c] = 0;
        if (!busy[c]) begin
          bus.core_req[c] = 1'b0;
          if (cmdq[c].size() > 0) begin
            k = cmdq[c].pop_front();
            if (k.kind != 2'd2) begin
              bus.core_req[c] = 1'b1;
              bus.core_we[c]  = k.kind[0];
              bus.core_addr[c*AWD +: AWD] = k.addr;
              bus.core_wdata[c*DW +: DW]  = k.data;
              e.we = k.kind[0];
              if (k.kind[0]) begin
                model[k.addr[7:0]] = k.data;
                e.data = '0;
              end else begin
                e.data = model[k.addr[7:0]];
              end
              e.ack_cyc = cyc + (bus.core_ack[c] ? 2 : 1);
              expq[c].push_back(e);
              busy[c] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic monitor_loop();
    logic [NC-1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = '0;
        continue;
      end
      if (bus.core_ack != '0) begin
        chk("ack_not_consecutive", bus.core_ack & prev, 0);
`ifndef DM_COALESCE_EN
        chk("ack_onehot", $countones(bus.core_ack), 1);
`endif
      end
      for (int c = 0; c < NC; c++) begin
        if (bus.core_ack[c]) begin
          last_ack_cyc[c] = cyc;
          if (expq[c].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: core %0d acked with no request outstanding", c);
          end else begin
            e = expq[c].pop_front();
            if (!e.we) chk($sformatf("load_data_core%0d", c), bus.core_rdata[c*DW +: DW], e.data);
            if (lat_chk) chk($sformatf("ack_latency_core%0d", c), cyc, e.ack_cyc);
          end
          if (order_chk) begin
            if (order_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL grant_order: extra ack from core %0d", c);
            end else begin
              chk("grant_order", c, order_q.pop_front());
            end
          end
        end
      end
      prev = bus.core_ack;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = 1;
      for (int c = 0; c < NC; c++)
        if (cmdq[c].size() != 0 || expq[c].size() != 0) done = 0;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_idle: requests not completed within cycle budget");
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Loader transfer; pend queues a core-1 load that arrives while LOAD runs,
  // abort resets during the second write.
  task automatic do_load(input logic [15:0] a, input logic [63:0] d, input bit pend, input bit abort);
    int acc;
    int dcyc;
    logic [15:0] w;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    acc = cyc;
    chk("ld_ready_idle", bus.ld_ready, 1);
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    if (abort) begin
      w = d[15:0];
      model[a[7:0]] = w;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_ld_ready", bus.ld_ready, 1);
      chk("abort_core_ack", bus.core_ack, 0);
      chk("abort_ld_done", bus.ld_done, 0);
      return;
    end
    for (int k = 0; k < NC; k++) begin
      w = d[k*16 +: 16];
      model[8'(a[7:0] + 8'(k))] = w;
    end
    if (pend) begin
      cmdq[1].push_back(mk(2'd0, a + 16'd1, 16'd0));
    end
    dcyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ld_done) begin
        dcyc = cyc;
        break;
      end
      chk("ld_ready_busy", bus.ld_ready, 0);
      if (cyc >= acc + 2) chk("no_grant_in_load", bus.core_ack, 0);
    end
    chk("ld_done_latency", dcyc - acc, 5);
    chk("ld_ready_at_done", bus.ld_ready, 1);
    ld_done_cyc = dcyc;
    @(negedge clk);
    chk("ld_done_one_cycle", bus.ld_done, 0);
  endtask

  task automatic gen_random(input int n, input logic [15:0] lbase);
    logic [15:0] a;
    int r;
    for (int c = 0; c < NC; c++) begin
      for (int j = 0; j < n; j++) begin
        r = $urandom_range(0, 9);
        if (r < 2) begin
          cmdq[c].push_back(mk(2'd2, 16'd0, 16'd0));
        end else if (r < 4) begin
          a = lbase + 16'($urandom_range(0, 3));
          cmdq[c].push_back(mk(2'd0, a, 16'd0));
        end else begin
          a = 16'h0080 + 16'(c * 16) + 16'($urandom_range(0, 15));
          a[15:8] = 8'($urandom_range(0, 255));
          if (r < 7 || !gvalid[a[7:0]]) begin
            gvalid[a[7:0]] = 1;
            cmdq[c].push_back(mk(2'd1, a, 16'($urandom)));
          end else begin
            cmdq[c].push_back(mk(2'd0, a, 16'd0));
          end
        end
      end
    end
  endtask

  initial begin
    logic [15:0] rbase;
    logic [63:0] rdata;
    logic [15:0] ld_addrs [NC];

    rst = 1'b1;
    bus.core_req   = '0;
    bus.core_we    = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    for (int i = 0; i < 256; i++) gvalid[i] = 0;
    for (int c = 0; c < NC; c++) last_ack_cyc[c] = -1;

    fork
      monitor_loop();
      driver_loop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_core_ack", bus.core_ack, 0);
    chk("reset_core_rdata", bus.core_rdata, 0);
    chk("reset_ld_ready", bus.ld_ready, 1);
    chk("reset_ld_done", bus.ld_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // store then load on the same address in consecutive cycles
    lat_chk = 1;
    cmdq[2].push_back(mk(2'd1, 16'h0010, 16'hBEEF));
    cmdq[2].push_back(mk(2'd0, 16'h0010, 16'd0));
    cmdq[1].push_back(mk(2'd2, 16'd0, 16'd0));
    cmdq[1].push_back(mk(2'd0, 16'h0010, 16'd0));
    wait_idle();
    lat_chk = 0;
    chk("core2_rdata_beef", bus.core_rdata[2*DW +: DW], 16'hBEEF);

    // loader wraps past the top of memory
    do_load(16'h00FE, 64'h4444_3333_2222_1111, 0, 0);
    ld_addrs[0] = 16'h00FE;
    ld_addrs[1] = 16'h00FF;
    ld_addrs[2] = 16'h0100;
    ld_addrs[3] = 16'h0001;
    for (int c = 0; c < NC; c++) cmdq[c].push_back(mk(2'd0, ld_addrs[c], 16'd0));
    wait_idle();
    chk("wrap_word_at_0", bus.core_rdata[2*DW +: DW], 16'h3333);

    // core 1 waits out a LOAD sequence
    do_load(16'h0030, 64'hA5A5_0F0F_1357_9BDF, 1, 0);
    wait_idle();
    chk("pending_ack_after_done", last_ack_cyc[1], ld_done_cyc + 1);

    // reset during the second loader write keeps only word 0
    cmdq[0].push_back(mk(2'd1, 16'h0040, 16'h9999));
    cmdq[0].push_back(mk(2'd1, 16'h0041, 16'hAAAA));
    cmdq[0].push_back(mk(2'd1, 16'h0042, 16'hBBBB));
    cmdq[0].push_back(mk(2'd1, 16'h0043, 16'hCCCC));
    wait_idle();
    do_load(16'h0040, 64'h7777_6666_5555_D00D, 0, 1);
    for (int k = 0; k < NC; k++) cmdq[3].push_back(mk(2'd0, 16'h0040 + 16'(k), 16'd0));
    wait_idle();

    // continuous loads from reset: rotating grant order
    do_reset();
    order_chk = 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NC; c++) order_q.push_back(c);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NC; c++) cmdq[c].push_back(mk(2'd0, ld_addrs[c], 16'd0));
    wait_idle();
    order_chk = 0;
    chk("grant_order_all_seen", order_q.size(), 0);

    // two cores loading the same address in the same cycle
    cmdq[2].push_back(mk(2'd1, 16'h0020, 16'h1234));
    wait_idle();
    cmdq[0].push_back(mk(2'd0, 16'h0020, 16'd0));
    cmdq[3].push_back(mk(2'd0, 16'h0020, 16'd0));
    wait_idle();
`ifdef DM_COALESCE_EN
    chk("coalesced_same_cycle", last_ack_cyc[0] == last_ack_cyc[3], 1);
`else
    chk("serialized_distinct_cycles", last_ack_cyc[0] != last_ack_cyc[3], 1);
`endif

    // randomized traffic with a random loader transfer
    for (int round = 0; round < 3; round++) begin
      rbase = 16'h00C0 + 16'($urandom_range(0, 12));
      rbase[15:8] = 8'($urandom_range(0, 255));
      rdata = {32'($urandom), 32'($urandom)};
      do_load(rbase, rdata, 0, 0);
      gen_random(30, rbase);
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
